// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage: fetches from instruction memory over req/ack,
// issues to decode over valid/ready, then waits for the branch unit's next PC.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] NPC,
  input  logic        NPC_valid,
  input  logic        HALT,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] INSTR,
  output logic        INSTR_valid,
  input  logic        INSTR_ready,
  output logic [31:0] PC,
  output logic [31:0] PC_plus_4,
  output logic        HALTED,
  output logic        MISALIGN,
  output logic [31:0] INSTR_COUNT
);

  // state    | meaning
  // IDLE     | single dead cycle after reset
  // FETCH    | imem_req high, waiting for imem_ack
  // ISSUE    | INSTR_valid high, waiting for INSTR_ready
  // WAIT_NPC | instruction issued, waiting for NPC_valid from execute
  // HALT_ST  | stopped by HALT or misaligned NPC; only rst leaves
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    ISSUE    = 3'd2,
    WAIT_NPC = 3'd3,
    HALT_ST  = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   halt_pending;
  logic   npc_take;
  logic   npc_misaligned;

  assign npc_take       = (state == WAIT_NPC) && NPC_valid;
  assign npc_misaligned = (NPC[1:0] != 2'b00);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     state_nxt = FETCH;
      FETCH:    if (imem_ack) state_nxt = ISSUE;
      ISSUE:    if (INSTR_ready) state_nxt = WAIT_NPC;
      WAIT_NPC: begin
        if (NPC_valid) begin
          if (npc_misaligned || halt_pending || HALT) state_nxt = HALT_ST;
          else                                         state_nxt = FETCH;
        end
      end
      HALT_ST:  state_nxt = HALT_ST;
      default:  state_nxt = IDLE;
    endcase
  end

  assign imem_req    = (state == FETCH);
  assign INSTR_valid = (state == ISSUE);
  assign HALTED      = (state == HALT_ST);
  assign imem_addr   = PC;
  assign PC_plus_4   = PC + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      PC           <= RESET_PC;
      INSTR        <= 32'd0;
      MISALIGN     <= 1'b0;
      INSTR_COUNT  <= 32'd0;
      halt_pending <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == FETCH) && imem_ack) INSTR <= imem_rdata;
      if ((state == ISSUE) && INSTR_ready) INSTR_COUNT <= INSTR_COUNT + 32'd1;
      if (npc_take) begin
        if (npc_misaligned) MISALIGN <= 1'b1;
        else                PC       <= NPC;
      end
      // A halt request is held until the next instruction boundary.
      if ((state != HALT_ST) && HALT) halt_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed vector table, hand-written halt/misalign/reset
// sequences, and randomized instruction streams against a transaction-level model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] NPC;
  logic        NPC_valid;
  logic        HALT;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] INSTR;
  logic        INSTR_valid;
  logic        INSTR_ready;
  logic [31:0] PC;
  logic [31:0] PC_plus_4;
  logic        HALTED;
  logic        MISALIGN;
  logic [31:0] INSTR_COUNT;

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .NPC(NPC), .NPC_valid(NPC_valid), .HALT(HALT),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .INSTR(INSTR), .INSTR_valid(INSTR_valid), .INSTR_ready(INSTR_ready),
    .PC(PC), .PC_plus_4(PC_plus_4), .HALTED(HALTED), .MISALIGN(MISALIGN),
    .INSTR_COUNT(INSTR_COUNT)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level model: architectural PC, issued count, halt/misalign flags.
  logic [31:0] m_pc;
  logic [31:0] m_count;
  bit          m_halted;
  bit          m_mis;
  bit          m_hp;
  bit          noise;

  typedef struct {
    int          lat;
    logic [31:0] data;
    int          stall;
    logic [31:0] npc;
    logic [31:0] exp_addr;
    logic [31:0] exp_p4;
    logic [31:0] exp_count;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit stale_ack);
    rst = 1'b1; NPC_valid = 1'b0; HALT = 1'b0; INSTR_ready = 1'b0;
    imem_ack = stale_ack; imem_rdata = 32'hBAD0_BAD0;
    step();
    imem_ack = 1'b0;
    m_pc = RST_PC; m_count = 32'd0; m_halted = 1'b0; m_mis = 1'b0; m_hp = 1'b0;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, INSTR_valid}, 32'd0);
    check("rst_halted", {31'd0, HALTED}, 32'd0);
    check("rst_misalign", {31'd0, MISALIGN}, 32'd0);
    check("rst_count", INSTR_COUNT, 32'd0);
    check("rst_pc", PC, RST_PC);
    check("rst_instr", INSTR, 32'd0);
    rst = 1'b0;
    step();
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, RST_PC);
  endtask

  // hmode: 0 no halt, 1 HALT pulse during ISSUE, 2 HALT coincident with NPC_valid.
  task automatic run_instr(input int lat, input logic [31:0] data, input int stall, input int gap,
                           input logic [31:0] npc, input int hmode,
                           output logic [31:0] got_addr, output logic [31:0] got_p4,
                           output logic [31:0] got_count);
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, m_pc);
    got_addr = imem_addr;
    for (int i = 0; i < lat; i++) begin
      if (noise) begin NPC_valid = 1'b1; NPC = $urandom; end
      step();
      NPC_valid = 1'b0;
    end
    check("fetch_hold", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1; imem_rdata = data;
    step();
    imem_ack = 1'b0; imem_rdata = $urandom;
    check("issue_valid", {31'd0, INSTR_valid}, 32'd1);
    check("issue_instr", INSTR, data);
    check("issue_pc", PC, m_pc);
    check("issue_p4", PC_plus_4, m_pc + 32'd4);
    check("issue_noreq", {31'd0, imem_req}, 32'd0);
    got_p4 = PC_plus_4;
    HALT = (hmode == 1);
    if (hmode == 1) m_hp = 1'b1;
    for (int i = 0; i < stall; i++) begin
      INSTR_ready = 1'b0;
      if (noise) begin imem_ack = 1'b1; imem_rdata = $urandom; NPC_valid = 1'b1; NPC = $urandom; end
      step();
      HALT = 1'b0; imem_ack = 1'b0; NPC_valid = 1'b0;
      check("stall_instr", INSTR, data);
      check("stall_pc", PC, m_pc);
      check("stall_valid", {31'd0, INSTR_valid}, 32'd1);
      check("stall_count", INSTR_COUNT, m_count);
    end
    INSTR_ready = 1'b1;
    step();
    INSTR_ready = 1'b0; HALT = 1'b0;
    m_count = m_count + 32'd1;
    check("hs_count", INSTR_COUNT, m_count);
    check("hs_valid", {31'd0, INSTR_valid}, 32'd0);
    got_count = INSTR_COUNT;
    for (int i = 0; i < gap; i++) begin
      step();
      check("wait_pc", PC, m_pc);
      check("wait_noreq", {31'd0, imem_req}, 32'd0);
    end
    NPC = npc; NPC_valid = 1'b1; HALT = (hmode == 2);
    step();
    NPC_valid = 1'b0; HALT = 1'b0;
    if (npc[1:0] != 2'b00) begin
      m_mis = 1'b1; m_halted = 1'b1;
    end else begin
      m_pc = npc;
      if (m_hp || hmode == 2) m_halted = 1'b1;
    end
    check("npc_pc", PC, m_pc);
    check("npc_halted", {31'd0, HALTED}, {31'd0, m_halted});
    check("npc_misalign", {31'd0, MISALIGN}, {31'd0, m_mis});
    check("npc_req", {31'd0, imem_req}, {31'd0, !m_halted});
    if (!m_halted) check("npc_addr", imem_addr, m_pc);
  endtask

  task automatic halted_idle(input int n);
    for (int i = 0; i < n; i++) begin
      NPC_valid = 1'b1; NPC = $urandom & 32'hFFFF_FFFC; imem_ack = 1'b1; imem_rdata = $urandom;
      HALT = 1'b1; INSTR_ready = 1'b1;
      step();
      NPC_valid = 1'b0; imem_ack = 1'b0; HALT = 1'b0; INSTR_ready = 1'b0;
      check("halt_req", {31'd0, imem_req}, 32'd0);
      check("halt_flag", {31'd0, HALTED}, 32'd1);
      check("halt_valid", {31'd0, INSTR_valid}, 32'd0);
      check("halt_pc", PC, m_pc);
      check("halt_mis", {31'd0, MISALIGN}, {31'd0, m_mis});
      check("halt_count", INSTR_COUNT, m_count);
    end
  endtask

  vec_t vecs[5];
  logic [31:0] ga, gp, gc;

  initial begin
    vecs[0] = '{2, 32'hDEAD_BEEF, 3, 32'h0000_0104, 32'h0000_0100, 32'h0000_0104, 32'd1};
    vecs[1] = '{0, 32'h1111_1111, 0, 32'h0000_0040, 32'h0000_0104, 32'h0000_0108, 32'd2};
    vecs[2] = '{1, 32'h2222_2222, 1, 32'hFFFF_FFFC, 32'h0000_0040, 32'h0000_0044, 32'd3};
    vecs[3] = '{0, 32'h3333_3333, 2, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 32'd4};
    vecs[4] = '{3, 32'h4444_4444, 0, 32'h0000_0048, 32'h0000_0000, 32'h0000_0004, 32'd5};

    noise = 1'b0; NPC = 32'd0; imem_rdata = 32'd0;
    do_reset(1'b0);
    for (int v = 0; v < 5; v++) begin
      run_instr(vecs[v].lat, vecs[v].data, vecs[v].stall, 1, vecs[v].npc, 0, ga, gp, gc);
      check("vec_addr", ga, vecs[v].exp_addr);
      check("vec_p4", gp, vecs[v].exp_p4);
      check("vec_count", gc, vecs[v].exp_count);
    end

    // Halt pulsed during ISSUE, then halt coincident with NPC_valid.
    for (int h = 1; h <= 2; h++) begin
      do_reset(1'b0);
      run_instr(1, 32'hCAFE_0000 + h, 2, 0, 32'h0000_0048, h, ga, gp, gc);
      check("halt_final_pc", PC, 32'h0000_0048);
      check("halt_final_flag", {31'd0, HALTED}, 32'd1);
      halted_idle(4);
    end

    // Misaligned next PC.
    do_reset(1'b0);
    run_instr(0, 32'h5555_5555, 1, 1, 32'h0000_0042, 0, ga, gp, gc);
    check("mis_pc", PC, RST_PC);
    check("mis_flag", {31'd0, MISALIGN}, 32'd1);
    halted_idle(3);

    // Reset while in FETCH with an ack on the same edge: stale data must not be captured.
    do_reset(1'b0);
    run_instr(0, 32'h7777_7777, 0, 0, 32'h0000_0200, 0, ga, gp, gc);
    do_reset(1'b1);
    step();
    check("stale_instr", INSTR, 32'd0);
    check("stale_req", {31'd0, imem_req}, 32'd1);

    // Randomized streams.
    noise = 1'b1;
    do_reset(1'b0);
    for (int t = 0; t < 60; t++) begin
      int hm;
      logic [31:0] npc;
      hm  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
      npc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 14) == 0) npc = npc | $urandom_range(1, 3);
      run_instr($urandom_range(0, 3), $urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                npc, hm, ga, gp, gc);
      if (m_halted) begin
        halted_idle(2);
        do_reset(1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
